except_seq: RTL and testbench
=============================

EXCEPT_SEQ -- requirements
Module: except_seq

Parameters
REQ-001 SHALL provide NUM_TRIG, default 14: number of exception trigger sources, 2..31.
REQ-002 SHALL provide TYPE_W, default 4: except_type width, >= ceil(log2(NUM_TRIG+1)).
REQ-003 SHALL provide PC_W, default 32: PC/EPCR width.
REQ-004 SHALL provide FLUSH_STAGES, default 5: total flush states including FLU1 and final, 3..16.
REQ-005 SHALL provide EXPC_MASK, default 0: NUM_TRIG bits; bit i=1 means source i saves ex_pc, else id_pc.
REQ-006 SHALL provide FAST_MASK, default 0: NUM_TRIG bits; bit i=1 means source i returns to IDLE from FLU2, as with trap.

Interface
REQ-007 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-008 reset  in  1  reset, asynchronous, active-low.
REQ-009 trig  in  NUM_TRIG  exception requests, level-sampled; higher index = higher priority.
REQ-010 trig_en  in  NUM_TRIG  per-source enable; disabled sources are ignored and never pended.
REQ-011 pc_we  in  1  SPR write to PC; forces a flush with except_type 0.
REQ-012 ex_dslot  in  1  EX stage holds a delay-slot instruction.
REQ-013 id_pc, ex_pc, wb_pc  in  PC_W each  stage PCs.
REQ-014 fetch_done  in  1  instruction-bus ack or error, or genpc_freeze.
REQ-015 if_stall, id_freeze  in  1 each  pipeline hold conditions.
REQ-016 flushpipe  out  1  one-cycle flush pulse.
REQ-017 except_type  out  TYPE_W  index+1 of the serviced source; 0 = none.
REQ-018 epcr  out  PC_W  saved exception PC.
REQ-019 busy  out  1  FSM not IDLE.
REQ-020 lost_cnt  out  8  count of dropped re-requests, saturating.

Function
REQ-021 Active trig SHALL be req = trig & trig_en; sel = highest set index of (req | pend) in IDLE.
REQ-022 States SHALL be IDLE, FLU1, FLU2, FLUM (counter), FLUL (last).
REQ-023 IDLE->FLU1 SHALL occur when (req|pend)!=0 or pc_we; flushpipe=1 that cycle only (combinational on entry condition, registered outputs next edge).
REQ-024 On that IDLE exit edge: except_type<=sel+1 (0 if only pc_we); epcr<=wb_pc if ex_dslot, else ex_pc if EXPC_MASK[sel], else id_pc; pc_we-only flush leaves epcr unchanged.
REQ-025 On that edge the pend bit of sel SHALL clear; other pend bits persist.
REQ-026 FLU1 SHALL hold until fetch_done=1, then go to FLU2.
REQ-027 FLU2 SHALL go to IDLE if except_type!=0 and FAST_MASK[except_type-1]; else to FLUM with cnt<=FLUSH_STAGES-4, or directly to FLUL if FLUSH_STAGES=3.
REQ-028 FLUM SHALL decrement cnt each cycle and go to FLUL when cnt==0.
REQ-029 FLUL SHALL go to IDLE when !if_stall && !id_freeze, else hold.
REQ-030 except_type SHALL return to 0 on every transition into IDLE; epcr SHALL hold until next capture.
REQ-031 While busy, each cycle: pend<=pend|req; any bit set in both req and pend with req bit newly asserted (rising vs previous cycle) SHALL increment lost_cnt, saturating at 255.
REQ-032 A request in the same cycle as return to IDLE SHALL be pended, not lost; next IDLE cycle SHALL re-enter FLU1 without idle gap requirement beyond one cycle.
REQ-033 pc_we while busy SHALL be ignored.
REQ-034 busy SHALL be 1 in every non-IDLE state.

Reset
REQ-035 reset=0 SHALL asynchronously force state=IDLE, cnt=0, pend=0, except_type=0, epcr=0, lost_cnt=0, flushpipe=0, busy=0, including mid-flush.

Verification
REQ-036 trig=0x2400 in IDLE, ex_dslot=0, EXPC_MASK=0 -> flushpipe pulse, except_type=0xE, epcr=id_pc.
REQ-037 trig[5], ex_dslot=1, wb_pc=0x100 -> epcr=0x100; fetch_done at cycle 3, if_stall=0 -> busy for exactly 2+(FLUSH_STAGES-2)+wait cycles, then IDLE with except_type=0.
REQ-038 FAST_MASK[13]=1, trig[13] -> FLU1->FLU2->IDLE, FLUM never entered.
REQ-039 trig[2] asserted, deasserted, reasserted during flush -> pend[2] set, lost_cnt=1, service of type 3 follows return to IDLE.
REQ-040 trig_en[7]=0 with trig[7]=1 -> no flush, pend stays 0; reset pulse during FLUM -> all outputs 0 immediately.

Source files
------------

// File: rtl/except_seq_if.sv
// Exception sequencer bus: trigger/pipeline-status inputs and flush/EPCR outputs.
// master = pipeline side that raises requests, slave = the sequencer.
interface except_seq_if #(
    parameter int NUM_TRIG = 14,
    parameter int TYPE_W   = 4,
    parameter int PC_W     = 32
);
    logic [NUM_TRIG-1:0] trig;
    logic [NUM_TRIG-1:0] trig_en;
    logic                pc_we;
    logic                ex_dslot;
    logic [PC_W-1:0]     id_pc;
    logic [PC_W-1:0]     ex_pc;
    logic [PC_W-1:0]     wb_pc;
    logic                fetch_done;
    logic                if_stall;
    logic                id_freeze;
    logic                flushpipe;
    logic [TYPE_W-1:0]   except_type;
    logic [PC_W-1:0]     epcr;
    logic                busy;
    logic [7:0]          lost_cnt;

    modport master (
        output trig, trig_en, pc_we, ex_dslot, id_pc, ex_pc, wb_pc,
               fetch_done, if_stall, id_freeze,
        input  flushpipe, except_type, epcr, busy, lost_cnt
    );

    modport slave (
        input  trig, trig_en, pc_we, ex_dslot, id_pc, ex_pc, wb_pc,
               fetch_done, if_stall, id_freeze,
        output flushpipe, except_type, epcr, busy, lost_cnt
    );
endinterface

// File: rtl/except_seq.sv
// Exception flush sequencer: flushpipe is combinational on IDLE exit, type/EPCR register on that edge.
// Requests arriving while busy are pended; re-raising an already pended request is counted as lost.
module except_seq #(
    parameter int                  NUM_TRIG     = 14,
    parameter int                  TYPE_W       = 4,
    parameter int                  PC_W         = 32,
    parameter int                  FLUSH_STAGES = 5,
    parameter logic [NUM_TRIG-1:0] EXPC_MASK    = '0,
    parameter logic [NUM_TRIG-1:0] FAST_MASK    = '0
) (
    input  logic         clk,
    input  logic         reset,
    except_seq_if.slave  bus
);
    localparam logic [3:0] CNT_INIT = 4'((FLUSH_STAGES > 3) ? FLUSH_STAGES - 4 : 0);

    typedef enum logic [2:0] {IDLE, FLU1, FLU2, FLUM, FLUL} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [NUM_TRIG-1:0] pend;
    logic [NUM_TRIG-1:0] req_q;
    logic [NUM_TRIG-1:0] req;
    logic [NUM_TRIG-1:0] cand;
    logic [NUM_TRIG-1:0] lost;
    logic [TYPE_W-1:0]   sel;
    logic                sel_expc;
    logic                fast;
    logic                start;

    always_comb begin
        req      = bus.trig & bus.trig_en;
        cand     = req | pend;
        sel      = '0;
        sel_expc = 1'b0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (cand[i]) begin
                sel      = TYPE_W'(i);
                sel_expc = EXPC_MASK[i];
            end
        end
        fast = 1'b0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (bus.except_type == TYPE_W'(i + 1)) fast = FAST_MASK[i];
        end
        lost  = req & pend & ~req_q;
        start = (state == IDLE) && ((|cand) || bus.pc_we);
    end

    // Gated by reset so the pulse is also quiet while reset is held with live triggers.
    assign bus.flushpipe = start & reset;
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            pend            <= '0;
            req_q           <= '0;
            bus.except_type <= '0;
            bus.epcr        <= '0;
            bus.lost_cnt    <= '0;
        end else begin
            req_q <= req;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FLU1;
                        if (|cand) begin
                            bus.except_type <= sel + TYPE_W'(1);
                            bus.epcr        <= bus.ex_dslot ? bus.wb_pc :
                                               sel_expc     ? bus.ex_pc : bus.id_pc;
                            pend            <= pend & ~(NUM_TRIG'(1) << sel);
                        end else begin
                            bus.except_type <= '0;
                        end
                    end
                end
                FLU1: if (bus.fetch_done) state <= FLU2;
                FLU2: begin
                    if (fast) begin
                        state           <= IDLE;
                        bus.except_type <= '0;
                    end else if (FLUSH_STAGES == 3) begin
                        state <= FLUL;
                    end else begin
                        state <= FLUM;
                        cnt   <= CNT_INIT;
                    end
                end
                FLUM: begin
                    if (cnt == 4'd0) state <= FLUL;
                    else             cnt   <= cnt - 4'd1;
                end
                FLUL: begin
                    if (!bus.if_stall && !bus.id_freeze) begin
                        state           <= IDLE;
                        bus.except_type <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Covers the return-to-IDLE cycle too, so a request there is pended.
            if (state != IDLE) begin
                pend <= pend | req;
                if ((|lost) && (bus.lost_cnt != 8'hFF)) bus.lost_cnt <= bus.lost_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_except_seq.sv
// Directed bench for except_seq: vector table for IDLE-exit capture, then hand sequences
// for flush timing, fast return, pend/lost handling, saturation and async reset.
module tb_except_seq;
    localparam int NUM_TRIG = 14;
    localparam int TYPE_W   = 4;
    localparam int PC_W     = 32;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   n;

    except_seq_if #(.NUM_TRIG(NUM_TRIG), .TYPE_W(TYPE_W), .PC_W(PC_W)) bus ();

    except_seq #(
        .NUM_TRIG(NUM_TRIG), .TYPE_W(TYPE_W), .PC_W(PC_W), .FLUSH_STAGES(5),
        .EXPC_MASK(14'h0008), .FAST_MASK(14'h2000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [13:0] trig;
        logic [13:0] en;
        logic        pc_we;
        logic        dslot;
        logic        flush;
        logic [3:0]  typ;
        logic [31:0] epcr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            bus.fetch_done = 1'b1;
            bus.if_stall   = 1'b0;
            bus.id_freeze  = 1'b0;
            @(posedge clk);
            #1;
            if (!bus.busy) return;
        end
        check("drain_timeout", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{14'h2400, 14'h3FFF, 1'b0, 1'b0, 1'b1, 4'hE, 32'h1000};
        vecs[1] = '{14'h0020, 14'h3FFF, 1'b0, 1'b1, 1'b1, 4'h6, 32'h3000};
        vecs[2] = '{14'h0008, 14'h3FFF, 1'b0, 1'b0, 1'b1, 4'h4, 32'h2000};
        vecs[3] = '{14'h0008, 14'h3FFF, 1'b0, 1'b1, 1'b1, 4'h4, 32'h3000};
        vecs[4] = '{14'h0000, 14'h3FFF, 1'b1, 1'b0, 1'b1, 4'h0, 32'h3000};
        vecs[5] = '{14'h0080, 14'h3F7F, 1'b0, 1'b0, 1'b0, 4'h0, 32'h3000};
        vecs[6] = '{14'h0001, 14'h3FFF, 1'b1, 1'b0, 1'b1, 4'h1, 32'h1000};
        vecs[7] = '{14'h3FFF, 14'h0FFF, 1'b0, 1'b0, 1'b1, 4'hC, 32'h1000};

        reset          = 1'b0;
        bus.trig       = '0;
        bus.trig_en    = '1;
        bus.pc_we      = 1'b0;
        bus.ex_dslot   = 1'b0;
        bus.id_pc      = 32'h1000;
        bus.ex_pc      = 32'h2000;
        bus.wb_pc      = 32'h3000;
        bus.fetch_done = 1'b0;
        bus.if_stall   = 1'b0;
        bus.id_freeze  = 1'b0;

        #12;
        check("rst_flush", 32'(bus.flushpipe), 32'd0);
        check("rst_type",  32'(bus.except_type), 32'd0);
        check("rst_epcr",  bus.epcr, 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_lost",  32'(bus.lost_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.trig       = vecs[i].trig;
            bus.trig_en    = vecs[i].en;
            bus.pc_we      = vecs[i].pc_we;
            bus.ex_dslot   = vecs[i].dslot;
            bus.fetch_done = 1'b0;
            #1;
            check($sformatf("v%0d_flush", i), 32'(bus.flushpipe), 32'(vecs[i].flush));
            @(posedge clk);
            #1;
            bus.trig    = '0;
            bus.pc_we   = 1'b0;
            bus.trig_en = '1;
            check($sformatf("v%0d_type", i), 32'(bus.except_type), 32'(vecs[i].typ));
            check($sformatf("v%0d_epcr", i), bus.epcr, vecs[i].epcr);
            check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].flush));
            drain();
            check($sformatf("v%0d_end_type", i), 32'(bus.except_type), 32'd0);
        end
        check("vec_lost", 32'(bus.lost_cnt), 32'd0);

        // Delay slot capture and exact busy length with a two-cycle fetch wait.
        @(negedge clk);
        bus.trig       = 14'h0020;
        bus.ex_dslot   = 1'b1;
        bus.wb_pc      = 32'h100;
        bus.fetch_done = 1'b0;
        @(posedge clk);
        #1;
        bus.trig     = '0;
        bus.ex_dslot = 1'b0;
        check("dslot_epcr", bus.epcr, 32'h100);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.fetch_done = (i >= 2);
            @(posedge clk);
            #1;
            if (!bus.busy) break;
            n++;
        end
        check("len_busy_cycles", 32'(n), 32'd7);
        check("len_end_type", 32'(bus.except_type), 32'd0);

        // Fast source returns from FLU2.
        @(negedge clk);
        bus.trig = 14'h2000;
        @(posedge clk);
        #1;
        bus.trig = '0;
        check("fast_type", 32'(bus.except_type), 32'hE);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.fetch_done = 1'b1;
            @(posedge clk);
            #1;
            if (!bus.busy) break;
            n++;
        end
        check("fast_busy_cycles", 32'(n), 32'd2);
        check("fast_end_type", 32'(bus.except_type), 32'd0);

        // Re-raised trig[2] during flush: pended, counted lost once, serviced afterwards.
        @(negedge clk);
        bus.trig       = 14'h0004;
        bus.fetch_done = 1'b0;
        @(posedge clk);
        #1;
        check("pend_type", 32'(bus.except_type), 32'h3);
        @(posedge clk);
        @(negedge clk);
        bus.trig = '0;
        @(posedge clk);
        @(negedge clk);
        bus.trig = 14'h0004;
        @(posedge clk);
        #1;
        check("pend_lost", 32'(bus.lost_cnt), 32'd1);
        @(negedge clk);
        bus.trig = '0;
        drain();
        check("pend_reflush", 32'(bus.flushpipe), 32'd1);
        @(posedge clk);
        #1;
        check("pend_busy2", 32'(bus.busy), 32'd1);
        check("pend_type2", 32'(bus.except_type), 32'h3);
        drain();
        check("pend_clear", 32'(bus.flushpipe), 32'd0);
        check("pend_lost_hold", 32'(bus.lost_cnt), 32'd1);

        // Saturate lost_cnt while stuck in FLU1.
        @(negedge clk);
        bus.trig       = 14'h0004;
        bus.fetch_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.trig = '0;
            @(posedge clk);
            @(negedge clk);
            bus.trig = 14'h0004;
            @(posedge clk);
        end
        #1;
        check("sat_lost", 32'(bus.lost_cnt), 32'd255);

        // Walk into FLUM, then reset asynchronously between edges.
        @(negedge clk);
        bus.trig       = '0;
        bus.fetch_done = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("flum_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_flush", 32'(bus.flushpipe), 32'd0);
        check("arst_type",  32'(bus.except_type), 32'd0);
        check("arst_epcr",  bus.epcr, 32'd0);
        check("arst_busy",  32'(bus.busy), 32'd0);
        check("arst_lost",  32'(bus.lost_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
